// File: rtl/input_debouncer.sv
// input_debouncer
// Conditions a raw asynchronous input for downstream edge/pulse detectors:
// a multi-flop synchronizer feeding a consecutive-sample debounce FSM, with
// registered rise/fall strobes and saturating debug counters.
//
// FSM states
//   state       | meaning
//   ------------+----------------------------------------------------------
//   STABLE_LOW  | level=0, synchronized input agrees with level
//   PEND_HIGH   | level=0, counting consecutive high samples
//   STABLE_HIGH | level=1, synchronized input agrees with level
//   PEND_LOW    | level=1, counting consecutive low samples
//
// The encoding puts level in state bit 1, so level comes straight off the
// state register and needs no extra flop.

module input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_async,
  input  logic             clear,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_count,
  output logic [CNT_W-1:0] glitch_count
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit so
  // the DEBOUNCE_CYCLES==1 build still elaborates cleanly.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    PEND_LOW    = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   a_s;

  state_t                 state_q;
  state_t                 state_d;
  logic [DB_W-1:0]        cnt_q;
  logic [DB_W-1:0]        cnt_d;
  logic                   glitch_evt;

  logic                   level_cur;
  logic                   rise_d;
  logic                   fall_d;

  // Plain shift chain; nothing may sit between the metastability stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_async};
    end
  end

  assign a_s = sync_q[SYNC_STAGES-1];

  // State register and qualification counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: count consecutive differing samples, abort on any agreeing one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    glitch_evt = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        if (a_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_HIGH;
          end else begin
            state_d = PEND_HIGH;
            cnt_d   = DB_W'(1);
          end
        end
      end
      PEND_HIGH: begin
        if (a_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HIGH;
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end else begin
          state_d    = STABLE_LOW;
          glitch_evt = 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!a_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = STABLE_LOW;
          end else begin
            state_d = PEND_LOW;
            cnt_d   = DB_W'(1);
          end
        end
      end
      PEND_LOW: begin
        if (!a_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LOW;
          end else begin
            cnt_d = cnt_q + DB_W'(1);
          end
        end else begin
          state_d    = STABLE_HIGH;
          glitch_evt = 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LOW;
      end
    endcase
  end

  // Outputs: level from the current state; strobes fire when the next state
  // lands on the opposite stable level (aborted pending states never do).
  always_comb begin
    level_cur = (state_q == STABLE_HIGH) || (state_q == PEND_LOW);
    rise_d    = (state_d == STABLE_HIGH) && !level_cur;
    fall_d    = (state_d == STABLE_LOW) && level_cur;
  end

  assign level = level_cur;

  // Strobes registered so they line up with the first cycle of the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= rise_d;
      fall <= fall_d;
    end
  end

  // Accepted-rise counter; clear beats a coincident increment, no wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_count <= '0;
    end else if (clear) begin
      rise_count <= '0;
    end else if (rise_d && (rise_count != CNT_MAX)) begin
      rise_count <= rise_count + CNT_W'(1);
    end
  end

  // Aborted-candidate counter; same clear and saturation rules.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_count <= '0;
    end else if (clear) begin
      glitch_count <= '0;
    end else if (glitch_evt && (glitch_count != CNT_MAX)) begin
      glitch_count <= glitch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer. Three instances share one stimulus:
//   u0: defaults (2 sync, 4 debounce, 8-bit counters)
//   u1: 3-bit counters, to reach saturation
//   u2: 3 sync stages, debounce of 1
// A run-length reference model predicts each instance per clock edge and
// queues the prediction; the monitor pops and compares on the falling edge.

module tb_input_debouncer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b1;
  logic a_async = 1'b0;
  logic clear   = 1'b0;
  logic done    = 1'b0;

  logic       lvl0, r0, f0, lvl1, r1, f1, lvl2, r2, f2;
  logic [7:0] rc0, gc0, rc2, gc2;
  logic [2:0] rc1, gc1;

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .a_async(a_async), .clear(clear),
    .level(lvl0), .rise(r0), .fall(f0), .rise_count(rc0), .glitch_count(gc0));

  input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .a_async(a_async), .clear(clear),
    .level(lvl1), .rise(r1), .fall(f1), .rise_count(rc1), .glitch_count(gc1));

  input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .a_async(a_async), .clear(clear),
    .level(lvl2), .rise(r2), .fall(f2), .rise_count(rc2), .glitch_count(gc2));

  typedef struct packed {
    logic       lvl;
    logic       r;
    logic       f;
    logic [7:0] rc;
    logic [7:0] gc;
  } obs_t;

  function automatic int p_sync(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic int p_deb(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int p_max(input int i);
    return (i == 1) ? 7 : 255;
  endfunction

  function automatic obs_t observe(input int i);
    obs_t o;
    case (i)
      0:       o = {lvl0, r0, f0, rc0, gc0};
      1:       o = {lvl1, r1, f1, 5'd0, rc1, 5'd0, gc1};
      default: o = {lvl2, r2, f2, rc2, gc2};
    endcase
    return o;
  endfunction

  // Reference model: the input reaches the debouncer p_sync edges late; level
  // flips once p_deb consecutive samples disagree with it; a disagreeing run
  // that ends early is a glitch.
  bit   hist[3][$];
  bit   m_lvl[3];
  int   m_run[3];
  int   m_rc[3];
  int   m_gc[3];
  obs_t sbq[3][$];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_lvl[i] = 1'b0;
      m_run[i] = 0;
      m_rc[i]  = 0;
      m_gc[i]  = 0;
      hist[i].delete();
      for (int s = 0; s < p_sync(i); s++) hist[i].push_back(1'b0);
      sbq[i].delete();
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit   samp;
      bit   r;
      bit   f;
      bit   g;
      obs_t e;
      r = 1'b0;
      f = 1'b0;
      g = 1'b0;
      hist[i].push_back(a_async);
      samp = hist[i].pop_front();
      if (samp != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == p_deb(i)) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          if (m_lvl[i]) r = 1'b1;
          else f = 1'b1;
        end
      end else begin
        if (m_run[i] > 0) g = 1'b1;
        m_run[i] = 0;
      end
      if (clear) begin
        m_rc[i] = 0;
        m_gc[i] = 0;
      end else begin
        if (r && m_rc[i] < p_max(i)) m_rc[i]++;
        if (g && m_gc[i] < p_max(i)) m_gc[i]++;
      end
      e.lvl = m_lvl[i];
      e.r   = r;
      e.f   = f;
      e.rc  = 8'(m_rc[i]);
      e.gc  = 8'(m_gc[i]);
      sbq[i].push_back(e);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // Monitor: all checks are counted here.
  int checks = 0;
  int errors = 0;
  bit saw_sat = 1'b0;

  initial begin
    obs_t o;
    obs_t e;
    while (!done) begin
      @(negedge clk or negedge rst_n);
      #1;
      for (int i = 0; i < 3; i++) begin
        o = observe(i);
        if (!rst_n) begin
          checks++;
          if (o !== '0) begin
            errors++;
            $display("FAIL reset u%0d t=%0t got lvl=%b rise=%b fall=%b rc=%0d gc=%0d, need all 0",
                     i, $time, o.lvl, o.r, o.f, o.rc, o.gc);
          end
        end else if (sbq[i].size() > 0) begin
          e = sbq[i].pop_front();
          checks++;
          if (o !== e) begin
            errors++;
            $display("FAIL scoreboard u%0d t=%0t got lvl=%b rise=%b fall=%b rc=%0d gc=%0d, need lvl=%b rise=%b fall=%b rc=%0d gc=%0d",
                     i, $time, o.lvl, o.r, o.f, o.rc, o.gc, e.lvl, e.r, e.f, e.rc, e.gc);
          end
          if (i == 1 && o.rc == 8'd7) saw_sat = 1'b1;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        errors++;
        $display("FAIL sb_drain u%0d got %0d pending entries, need 0", i, sbq[i].size());
      end
    end
    checks++;
    if (saw_sat != 1'b1) begin
      errors++;
      $display("FAIL saturation u1 got saw_sat=%b, need 1", saw_sat);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: stimulus did not complete by t=%0t", $time);
    $fatal(1, "timeout");
  end

  // Stimulus: inputs change 2 time units after each rising edge.
  task automatic tick(input logic a, input logic c);
    a_async = a;
    clear   = c;
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic a, input int n);
    for (int k = 0; k < n; k++) tick(a, 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic a;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2;
    tick(1'b0, 1'b0);
    rst_n = 1'b1;
    hold(1'b0, 8);

    // Reset while the input sits high, then requalify from scratch.
    hold(1'b1, 10);
    pulse_reset();
    hold(1'b1, 8);
    hold(1'b0, 10);

    // Clean steps up and down.
    hold(1'b1, 12);
    hold(1'b0, 12);

    // Three-cycle glitch.
    hold(1'b1, 3);
    hold(1'b0, 10);

    // Bounce inside the pending window.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    hold(1'b1, 10);
    hold(1'b0, 10);

    // Nine clean pulses drive the 3-bit counter into saturation.
    for (int p = 0; p < 9; p++) begin
      hold(1'b1, 8);
      hold(1'b0, 8);
    end

    // Clear on the same edge the debounced rise is accepted.
    hold(1'b1, 5);
    tick(1'b1, 1'b1);
    hold(1'b1, 4);
    hold(1'b0, 10);

    // Reset during a pending rise discards it.
    hold(1'b1, 3);
    pulse_reset();
    hold(1'b0, 10);

    // Randomized toggling, sporadic clears and resets.
    for (int it = 0; it < 300; it++) begin
      a = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) tick(a, ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 59) == 0) pulse_reset();
    end

    hold(1'b0, 10);
    done = 1'b1;
  end

endmodule
